// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation encodings,
// burst controller states and a helper that identifies steppable modes.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_CLR  = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // Only shifts and rotates can be repeated by the burst engine.
    function automatic logic is_step_mode(input mode_e m);
        return m inside {MODE_SHR, MODE_SHL, MODE_ROR, MODE_ROL};
    endfunction

endpackage

// File: rtl/usr_burst_ctrl.sv
// Burst engine: IDLE/RUN/DONE FSM with a down-counter. It decides whether
// the datapath applies the live mode, the latched burst mode, or holds.
module usr_burst_ctrl
    import usr_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             resetn,
    input  mode_e            mode,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             manual_en,
    output logic             step_en,
    output logic             busy,
    output logic             done,
    output mode_e            bmode
);

    state_e           state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            bmode <= MODE_HOLD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (burst_start) begin
                        bmode <= mode;
                        cnt   <= burst_len;
                        // Empty or non-stepping bursts complete without touching q.
                        if (burst_len == '0 || !is_step_mode(mode))
                            state <= ST_DONE;
                        else
                            state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1))
                        state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_DONE);
    assign step_en   = busy;
    // A start pulse in IDLE pre-empts the manual operation on that edge.
    assign manual_en = (state == ST_IDLE) && !burst_start;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register datapath: mode mux and the q register, with the
// burst engine selecting which operation is applied on each edge.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [2:0]       mode,
    input  logic             sin_msb,
    input  logic             sin_lsb,
    input  logic [WIDTH-1:0] pin,
    input  logic             burst_start,
    input  logic [CNT_W-1:0] burst_len,
    output logic [WIDTH-1:0] pout,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    logic             manual_en;
    logic             step_en;
    mode_e            bmode;
    mode_e            op;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_nxt;

    usr_burst_ctrl #(
        .CNT_W(CNT_W)
    ) u_ctrl (
        .clk        (clk),
        .resetn     (resetn),
        .mode       (mode_e'(mode)),
        .burst_start(burst_start),
        .burst_len  (burst_len),
        .manual_en  (manual_en),
        .step_en    (step_en),
        .busy       (busy),
        .done       (done),
        .bmode      (bmode)
    );

    always_comb begin
        op = MODE_HOLD;
        if (step_en)
            op = bmode;
        else if (manual_en)
            op = mode_e'(mode);
    end

    // Serial inputs are used live, so a burst sees them change every step.
    always_comb begin
        q_nxt = q;
        case (op)
            MODE_SHR:  q_nxt = {sin_msb, q[WIDTH-1:1]};
            MODE_SHL:  q_nxt = {q[WIDTH-2:0], sin_lsb};
            MODE_ROR:  q_nxt = {q[0], q[WIDTH-1:1]};
            MODE_ROL:  q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
            MODE_LOAD: q_nxt = pin;
            MODE_CLR:  q_nxt = '0;
            default:   q_nxt = q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            q <= '0;
        else
            q <= q_nxt;
    end

    assign pout     = q;
    assign sout_lsb = q[0];
    assign sout_msb = q[WIDTH-1];

endmodule
